// File: rtl/sram_req_master_pkg.sv
// Shared definitions for the sram_ctl request front end: FSM encoding,
// rw_o polarity, default timeout and the alignment rule.
package sram_req_master_pkg;

  typedef enum logic [1:0] {
    SRM_IDLE  = 2'd0,
    SRM_ISSUE = 2'd1,
    SRM_WAIT  = 2'd2,
    SRM_RESP  = 2'd3
  } srm_state_e;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam int DEFAULT_TIMEOUT = 255;

  // An unaligned byte address is only legal when the enables name exactly one byte.
  function automatic logic is_misaligned(input logic [1:0] offset, input logic [3:0] be);
    logic single_byte;
    single_byte = (be == 4'b0001) || (be == 4'b0010) || (be == 4'b0100) || (be == 4'b1000);
    return (offset != 2'b00) && !single_byte;
  endfunction

endpackage

// File: rtl/sram_req_master.sv
// Initiator-side front end for sram_ctl: one outstanding request at a time,
// valid/ready request and response channels, alignment check and completion timeout.
module sram_req_master
  import sram_req_master_pkg::*;
#(
  parameter int ADDR_W  = 24,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [31:0]       req_addr_i,
  input  logic [3:0]        req_be_i,
  input  logic [31:0]       req_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [31:0]       rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              start_o,
  output logic              rw_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [31:0]       data_o,
  output logic [3:0]        data_be_o,
  input  logic [31:0]       data_i,
  input  logic              r_ready_i,
  input  logic              w_finish_i,
  input  logic              busy_i
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  // The WAIT cycle in which the counter holds this value is the last one a strobe can win.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  srm_state_e       state;
  logic [CNT_W-1:0] tmo_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= SRM_IDLE;
      start_o     <= 1'b0;
      req_ready_o <= 1'b1;
      rsp_valid_o <= 1'b0;
      rsp_err_o   <= 1'b0;
      rsp_rdata_o <= 32'h0;
      rw_o        <= RW_READ;
      addr_o      <= '0;
      data_o      <= 32'h0;
      data_be_o   <= 4'b1111;
      tmo_cnt     <= '0;
    end else begin
      case (state)
        SRM_IDLE: begin
          if (req_valid_i) begin
            rw_o        <= req_we_i ? RW_WRITE : RW_READ;
            addr_o      <= req_addr_i[ADDR_W+1:2];
            data_o      <= req_wdata_i;
            data_be_o   <= req_we_i ? ~req_be_i : 4'b0000;
            rsp_rdata_o <= 32'h0;
            rsp_err_o   <= 1'b0;
            req_ready_o <= 1'b0;
            if (is_misaligned(req_addr_i[1:0], req_be_i)) begin
              rsp_err_o   <= 1'b1;
              rsp_valid_o <= 1'b1;
              state       <= SRM_RESP;
            end else if (req_we_i && (req_be_i == 4'b0000)) begin
              rsp_valid_o <= 1'b1;
              state       <= SRM_RESP;
            end else begin
              // Start in the first ISSUE cycle when the controller is already idle.
              start_o <= ~busy_i;
              state   <= SRM_ISSUE;
            end
          end
        end

        SRM_ISSUE: begin
          if (start_o) begin
            start_o <= 1'b0;
            tmo_cnt <= '0;
            state   <= SRM_WAIT;
          end else if (!busy_i) begin
            start_o <= 1'b1;
          end
        end

        SRM_WAIT: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if ((rw_o == RW_READ) && r_ready_i) begin
            rsp_rdata_o <= data_i;
            rsp_valid_o <= 1'b1;
            state       <= SRM_RESP;
          end else if ((rw_o == RW_WRITE) && w_finish_i) begin
            rsp_valid_o <= 1'b1;
            state       <= SRM_RESP;
          end else if (tmo_cnt == CNT_LAST) begin
            rsp_err_o   <= 1'b1;
            rsp_rdata_o <= 32'h0;
            rsp_valid_o <= 1'b1;
            state       <= SRM_RESP;
          end
        end

        SRM_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            req_ready_o <= 1'b1;
            state       <= SRM_IDLE;
          end
        end

        default: state <= SRM_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_req_master.sv
// Directed bench for sram_req_master with a behavioural controller stub,
// a response scoreboard queue and immediate-assertion checks.
module tb_sram_req_master;
  import sram_req_master_pkg::*;

  localparam int ADDR_W  = 24;
  localparam int TIMEOUT = 8;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              req_valid_i;
  logic              req_ready_o;
  logic              req_we_i;
  logic [31:0]       req_addr_i;
  logic [3:0]        req_be_i;
  logic [31:0]       req_wdata_i;
  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [31:0]       rsp_rdata_o;
  logic              rsp_err_o;
  logic              start_o;
  logic              rw_o;
  logic [ADDR_W-1:0] addr_o;
  logic [31:0]       data_o;
  logic [3:0]        data_be_o;
  logic [31:0]       data_i;
  logic              r_ready_i;
  logic              w_finish_i;
  logic              busy_i;

  always #5 clk_i = ~clk_i;

  sram_req_master #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_addr_i(req_addr_i), .req_be_i(req_be_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o), .start_o(start_o), .rw_o(rw_o), .addr_o(addr_o),
    .data_o(data_o), .data_be_o(data_be_o), .data_i(data_i), .r_ready_i(r_ready_i),
    .w_finish_i(w_finish_i), .busy_i(busy_i)
  );

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } exp_rsp_t;

  exp_rsp_t    exp_q[$];
  int          total = 0;
  int          bad = 0;
  int          start_count = 0;
  int          double_start = 0;
  logic        prev_start = 1'b0;
  logic        stub_mute = 1'b0;
  logic        stray_rd = 1'b0;
  logic [31:0] mem [0:255];

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drives one request and returns at the falling edge of the cycle after acceptance.
  task automatic apply_stimulus(input string tag, input logic we, input logic [31:0] addr,
                                input logic [3:0] be, input logic [31:0] wdata);
    int n = 0;
    req_valid_i = 1'b1;
    req_we_i    = we;
    req_addr_i  = addr;
    req_be_i    = be;
    req_wdata_i = wdata;
    while (!req_ready_o && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    check_output({tag, "_accept"}, req_ready_o, 32'h1);
    @(negedge clk_i);
    req_valid_i = 1'b0;
  endtask

  task automatic wait_response(input string tag, input int hold, output int cycles);
    int       n = 0;
    exp_rsp_t e;
    while (!rsp_valid_o && n < 40) begin
      @(negedge clk_i);
      n++;
    end
    cycles = n;
    check_output({tag, "_rsp_valid"}, rsp_valid_o, 32'h1);
    check_output({tag, "_q_nonempty"}, (exp_q.size() != 0), 32'h1);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
    for (int i = 0; i < hold; i++) begin
      rsp_ready_i = 1'b0;
      check_output({tag, "_hold_err"}, rsp_err_o, e.err);
      check_output({tag, "_hold_rdata"}, rsp_rdata_o, e.rdata);
      check_output({tag, "_hold_req_ready"}, req_ready_o, 32'h0);
      @(negedge clk_i);
    end
    check_output({tag, "_err"}, rsp_err_o, e.err);
    check_output({tag, "_rdata"}, rsp_rdata_o, e.rdata);
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    rsp_ready_i = 1'b0;
    check_output({tag, "_ready_after"}, req_ready_o, 32'h1);
    check_output({tag, "_valid_after"}, rsp_valid_o, 32'h0);
  endtask

  // Start-pulse monitor: counts pulses and flags any two-cycle pulse.
  initial begin
    forever begin
      @(negedge clk_i);
      if (start_o === 1'b1) begin
        start_count++;
        if (prev_start) double_start++;
      end
      prev_start = (start_o === 1'b1);
    end
  end

  // Controller stub: answers a start two cycles later with the matching strobe.
  initial begin
    logic        pending;
    int          lat;
    logic        c_rw;
    logic [7:0]  c_addr;
    logic [31:0] c_data;
    logic [3:0]  c_be_n;
    pending = 1'b0;
    lat = 0;
    c_rw = 1'b0;
    c_addr = 8'h0;
    c_data = 32'h0;
    c_be_n = 4'hF;
    data_i = 32'h0;
    r_ready_i = 1'b0;
    w_finish_i = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    forever begin
      @(negedge clk_i);
      r_ready_i = 1'b0;
      w_finish_i = 1'b0;
      if (rst_i) begin
        pending = 1'b0;
      end else begin
        if (pending) begin
          if (lat == 0) begin
            pending = 1'b0;
            if (c_rw == RW_READ) begin
              data_i = mem[c_addr];
              r_ready_i = 1'b1;
            end else begin
              for (int b = 0; b < 4; b++)
                if (!c_be_n[b]) mem[c_addr][8*b +: 8] = c_data[8*b +: 8];
              w_finish_i = 1'b1;
            end
          end else begin
            lat--;
          end
        end
        if (start_o && !stub_mute) begin
          pending = 1'b1;
          lat = 2;
          c_rw = rw_o;
          c_addr = addr_o[7:0];
          c_data = data_o;
          c_be_n = data_be_o;
        end
      end
      if (stray_rd) begin
        data_i = 32'hBAD0BAD0;
        r_ready_i = 1'b1;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cyc;
    int sc;
    rst_i = 1'b1;
    req_valid_i = 1'b0;
    req_we_i = 1'b0;
    req_addr_i = 32'h0;
    req_be_i = 4'h0;
    req_wdata_i = 32'h0;
    rsp_ready_i = 1'b0;
    busy_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    check_output("rst_req_ready", req_ready_o, 32'h1);
    check_output("rst_rsp_valid", rsp_valid_o, 32'h0);
    check_output("rst_rsp_err", rsp_err_o, 32'h0);
    check_output("rst_rsp_rdata", rsp_rdata_o, 32'h0);
    check_output("rst_start", start_o, 32'h0);
    check_output("rst_rw", rw_o, 32'h1);
    check_output("rst_addr", addr_o, 32'h0);
    check_output("rst_data", data_o, 32'h0);
    check_output("rst_data_be", data_be_o, 32'hF);
    rst_i = 1'b0;
    @(negedge clk_i);

    // Full-word write.
    sc = start_count;
    exp_q.push_back(exp_rsp_t'{err: 1'b0, rdata: 32'h0});
    apply_stimulus("wr_word", 1'b1, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF);
    check_output("wr_word_start", start_o, 32'h1);
    check_output("wr_word_addr", addr_o, 32'h4);
    check_output("wr_word_be", data_be_o, 32'h0);
    check_output("wr_word_rw", rw_o, 32'h0);
    check_output("wr_word_data", data_o, 32'hDEAD_BEEF);
    wait_response("wr_word", 0, cyc);
    check_output("wr_word_latency", cyc, 32'd4);
    check_output("wr_word_starts", start_count - sc, 32'd1);

    exp_q.push_back(exp_rsp_t'{err: 1'b0, rdata: 32'hDEAD_BEEF});
    apply_stimulus("rd_word", 1'b0, 32'h0000_0010, 4'hF, 32'h0);
    check_output("rd_word_start", start_o, 32'h1);
    check_output("rd_word_rw", rw_o, 32'h1);
    check_output("rd_word_be", data_be_o, 32'h0);
    wait_response("rd_word", 0, cyc);

    // Byte write into the top lane, then read the merged word.
    exp_q.push_back(exp_rsp_t'{err: 1'b0, rdata: 32'h0});
    apply_stimulus("wr_byte", 1'b1, 32'h0000_0013, 4'b1000, 32'h1122_3344);
    check_output("wr_byte_addr", addr_o, 32'h4);
    check_output("wr_byte_be", data_be_o, 32'h7);
    wait_response("wr_byte", 0, cyc);
    exp_q.push_back(exp_rsp_t'{err: 1'b0, rdata: 32'h11AD_BEEF});
    apply_stimulus("rd_merge", 1'b0, 32'h0000_0010, 4'hF, 32'h0);
    wait_response("rd_merge", 0, cyc);

    // Misaligned read and empty write never reach the controller.
    sc = start_count;
    exp_q.push_back(exp_rsp_t'{err: 1'b1, rdata: 32'h0});
    apply_stimulus("misalign", 1'b0, 32'h0000_0012, 4'hF, 32'h0);
    wait_response("misalign", 0, cyc);
    check_output("misalign_latency", cyc, 32'd0);
    exp_q.push_back(exp_rsp_t'{err: 1'b0, rdata: 32'h0});
    apply_stimulus("noop_wr", 1'b1, 32'h0000_0010, 4'h0, 32'hFFFF_FFFF);
    wait_response("noop_wr", 0, cyc);
    check_output("no_start_count", start_count - sc, 32'd0);

    // Busy-delayed start followed by a timeout from a silent controller.
    stub_mute = 1'b1;
    busy_i = 1'b1;
    sc = start_count;
    exp_q.push_back(exp_rsp_t'{err: 1'b1, rdata: 32'h0});
    apply_stimulus("tmo", 1'b0, 32'h0000_0010, 4'hF, 32'h0);
    for (int i = 0; i < 5; i++) begin
      check_output("tmo_busy_nostart", start_o, 32'h0);
      @(negedge clk_i);
    end
    busy_i = 1'b0;
    check_output("tmo_busy_fall_nostart", start_o, 32'h0);
    @(negedge clk_i);
    check_output("tmo_start", start_o, 32'h1);
    wait_response("tmo", 0, cyc);
    check_output("tmo_latency", cyc, TIMEOUT + 1);
    check_output("tmo_starts", start_count - sc, 32'd1);
    stub_mute = 1'b0;

    // Response held off by the consumer.
    exp_q.push_back(exp_rsp_t'{err: 1'b0, rdata: 32'h11AD_BEEF});
    apply_stimulus("stall", 1'b0, 32'h0000_0010, 4'hF, 32'h0);
    wait_response("stall", 4, cyc);

    // Reset during WAIT abandons the access; a stray strobe afterwards is ignored.
    stub_mute = 1'b1;
    apply_stimulus("abort", 1'b0, 32'h0000_0010, 4'hF, 32'h0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    check_output("abort_req_ready", req_ready_o, 32'h1);
    check_output("abort_rsp_valid", rsp_valid_o, 32'h0);
    check_output("abort_start", start_o, 32'h0);
    @(posedge clk_i);
    stray_rd = 1'b1;
    @(posedge clk_i);
    stray_rd = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      check_output("stray_rsp_valid", rsp_valid_o, 32'h0);
      check_output("stray_req_ready", req_ready_o, 32'h1);
    end
    stub_mute = 1'b0;
    busy_i = 1'b1;
    exp_q.push_back(exp_rsp_t'{err: 1'b0, rdata: 32'h11AD_BEEF});
    apply_stimulus("post_rst", 1'b0, 32'h0000_0010, 4'hF, 32'h0);
    check_output("post_rst_wait_busy", start_o, 32'h0);
    @(negedge clk_i);
    busy_i = 1'b0;
    @(negedge clk_i);
    check_output("post_rst_start", start_o, 32'h1);
    wait_response("post_rst", 0, cyc);

    check_output("queue_drained", exp_q.size(), 32'd0);
    check_output("no_double_start", double_start, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
